// File: rtl/core_pkg.sv
// Shared core definitions for the program-counter sequencer.
//  pc_seq_state_e : sequencer FSM states
//  XLEN           : architectural register / address width
//  INST_BYTES     : instruction size in bytes (sequential PC step)
//  DEF_RESET_PC   : default first fetch address
//  word_align     : clears the sub-word bits of an address
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pc_seq_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer.
// Arbitrates trap / redirect / halt / stall / sequential PC sources and
// inserts flush bubbles after every control transfer. All outputs registered.
//  clk, rstn        : clock, synchronous active-low reset
//  hazard_stall     : hold PC (RUN only)
//  decode_ready     : PC advances only when high
//  redirect_valid   : taken branch/jump, target on redirect_pc
//  trap_valid       : exception, target on trap_vec (highest priority)
//  halt_req, resume : debug halt level / resume pulse
//  pc_out           : address presented to fetch
//  fetch_stall      : fetch stall
//  flush            : squash in-flight fetch/decode
//  pc_valid         : pc_out is a real fetch address
//  halted           : core halted for debug
//  misalign         : 1-cycle pulse, redirect target had low bits set
module pc_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC         = DEF_RESET_PC,
  parameter int unsigned     REDIRECT_BUBBLES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            hazard_stall,
  input  logic            decode_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_stall,
  output logic            flush,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign
);

  // Counter reload: bubbles already include the entry cycle.
  localparam logic [2:0] BUB_LOAD = 3'(REDIRECT_BUBBLES - 1);

  pc_seq_state_e   state, state_n;
  logic [XLEN-1:0] pc_n;
  logic [2:0]      cnt, cnt_n;
  logic            mis_n;
  logic            hold_n;

  always_comb begin
    state_n = state;
    pc_n    = pc_out;
    cnt_n   = 3'd0;
    mis_n   = 1'b0;
    hold_n  = 1'b0;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_n    = word_align(trap_vec);
          state_n = FLUSH;
          cnt_n   = BUB_LOAD;
        end else if (redirect_valid) begin
          pc_n    = word_align(redirect_pc);
          mis_n   = |redirect_pc[1:0];
          state_n = FLUSH;
          cnt_n   = BUB_LOAD;
        end else if (halt_req) begin
          state_n = HALT;
        end else if (hazard_stall || !decode_ready) begin
          hold_n  = 1'b1;
        end else begin
          pc_n    = pc_out + XLEN'(INST_BYTES);
        end
      end
      FLUSH: begin
        // A fresh control transfer restarts the bubble window.
        if (trap_valid) begin
          pc_n  = word_align(trap_vec);
          cnt_n = BUB_LOAD;
        end else if (redirect_valid) begin
          pc_n  = word_align(redirect_pc);
          mis_n = |redirect_pc[1:0];
          cnt_n = BUB_LOAD;
        end else if (cnt == 3'd0) begin
          state_n = halt_req ? HALT : RUN;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      HALT: begin
        // Redirects are ignored here: the pipeline is already drained.
        if (trap_valid) begin
          pc_n    = word_align(trap_vec);
          state_n = FLUSH;
          cnt_n   = BUB_LOAD;
        end else if (resume) begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= BOOT;
      pc_out      <= RESET_PC;
      cnt         <= 3'd0;
      fetch_stall <= 1'b1;
      flush       <= 1'b1;
      pc_valid    <= 1'b0;
      halted      <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_n;
      pc_out      <= pc_n;
      cnt         <= cnt_n;
      fetch_stall <= (state_n == HALT) || hold_n;
      flush       <= (state_n == FLUSH);
      pc_valid    <= (state_n == RUN);
      halted      <= (state_n == HALT);
      misalign    <= mis_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hazard_stall, decode_ready, redirect_valid, trap_valid;
  logic        halt_req, resume;
  logic [31:0] redirect_pc, trap_vec;
  logic [31:0] pc_out;
  logic        fetch_stall, flush, pc_valid, halted, misalign;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk(clk), .rstn(rstn),
    .hazard_stall(hazard_stall), .decode_ready(decode_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .halt_req(halt_req), .resume(resume),
    .pc_out(pc_out), .fetch_stall(fetch_stall), .flush(flush),
    .pc_valid(pc_valid), .halted(halted), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // pc, pc_valid, flush, fetch_stall, halted
  task automatic chk5(input string tag, input logic [31:0] pc, input logic v,
                      input logic f, input logic s, input logic h);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, v});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
    chk({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, s});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    rstn = 1'b0; hazard_stall = 1'b0; decode_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; trap_valid = 1'b0; trap_vec = '0;
    halt_req = 1'b0; resume = 1'b0;
    step(); step();
    chk5("reset", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("reset.misalign", {31'd0, misalign}, 32'd0);

    // 1: boot then sequential fetch
    rstn = 1'b1;
    step(); chk5("boot", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("seq4", pc_out, 32'h4);
    step(); chk("seq8", pc_out, 32'h8);
    step(); chk("seqC", pc_out, 32'hC);
    step(); chk("seq10", pc_out, 32'h10);

    // 2: redirect with two flush bubbles
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(); chk5("redir.b0", 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("redir.mis", {31'd0, misalign}, 32'd0);
    redirect_valid = 1'b0;
    step(); chk5("redir.b1", 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); chk5("redir.run", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("redir.next", pc_out, 32'h104);

    // 3: trap beats a simultaneous (misaligned) redirect
    trap_valid = 1'b1; trap_vec = 32'h80; redirect_valid = 1'b1; redirect_pc = 32'h203;
    step(); chk5("trap", 32'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("trap.mis", {31'd0, misalign}, 32'd0);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    step(); step(); chk5("trap.run", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: misaligned redirect, then re-redirect during FLUSH
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step(); chk("mis.pc", pc_out, 32'h100);
    chk("mis.pulse", {31'd0, misalign}, 32'd1);
    redirect_valid = 1'b0;
    step(); chk("mis.drop", {31'd0, misalign}, 32'd0);
    chk("mis.flush", {31'd0, flush}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); chk5("rere.b0", 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    step(); chk5("rere.b1", 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); chk5("rere.run", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("rere.next", pc_out, 32'h44);

    // 5: wrap-around and stalls
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    step(); step(); chk5("wrap.top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("wrap.zero", pc_out, 32'h0);
    hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk5("hazard", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    hazard_stall = 1'b0;
    step(); chk5("hazard.rel", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    decode_ready = 1'b0;
    step(); chk5("notready", 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    decode_ready = 1'b1;
    step(); chk("ready.rel", pc_out, 32'h8);

    // 6: debug halt / resume
    halt_req = 1'b1;
    step(); chk5("halt", 32'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step(); chk5("halt.noredir", 32'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b1;
    step(); chk5("resume", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    resume = 1'b0;
    step(); chk("resume.adv", pc_out, 32'hC);
    halt_req = 1'b1;
    step(); chk("halt2", {31'd0, halted}, 32'd1);
    resume = 1'b1;
    step(); chk5("both.resume", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    resume = 1'b0;
    step(); chk5("both.rehalt", 32'hC, 1'b0, 1'b0, 1'b1, 1'b1);
    trap_valid = 1'b1; trap_vec = 32'h81;
    step(); chk5("halt.trap", 32'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    trap_valid = 1'b0;
    step(); step(); chk5("flush.halt", 32'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    rstn = 1'b0;
    step(); chk5("rst.halt", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    rstn = 1'b1; halt_req = 1'b0;
    step(); chk5("rst.boot", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a flush leaves no residual bubbles
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); redirect_valid = 1'b0;
    rstn = 1'b0;
    step(); chk5("rst.flush", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    rstn = 1'b1;
    step(); chk5("rst.flush.boot", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("rst.flush.adv", pc_out, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
